// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding,
// default end-of-program marker and byte-index width.
package imem_loader_pkg;

   localparam int STATE_W = 3;
   localparam int BYTE_W  = 8;
   localparam int IDX_W   = 2;

   localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] S_COLLECT = 3'd1;
   localparam logic [STATE_W-1:0] S_WRITE   = 3'd2;
   localparam logic [STATE_W-1:0] S_CSUM    = 3'd3;
   localparam logic [STATE_W-1:0] S_DONE    = 3'd4;
   localparam logic [STATE_W-1:0] S_ERROR   = 3'd5;

   localparam logic [31:0] END_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_loader_assembler.sv
// Byte-to-word shift register: bytes land big-endian (first byte in [31:24]),
// word_valid flags the cycle the fourth byte of a word is accepted.
module imem_loader_assembler
   import imem_loader_pkg::*;
#(
   parameter int B = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [BYTE_W-1:0] i_byte,
   output logic              o_word_valid,
   output logic [B-1:0]      o_word
);

   logic [IDX_W-1:0] r_idx;
   logic [B-1:0]     r_word;
   logic [IDX_W-1:0] w_lane;

   // Lane 3-idx equals the bitwise inverse of a 2-bit index.
   assign w_lane = ~r_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx  <= '0;
      end else if (i_accept) begin
         r_word[{w_lane, 3'b000} +: BYTE_W] <= i_byte;
         r_idx                              <= r_idx + 1'b1;
      end
   end

   assign o_word_valid = i_accept && (r_idx == '1);
   assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Program loader: assembles a byte stream into 32-bit words, writes them to
// instruction memory from address 0 and holds the pipeline until the end
// marker is stored. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          B        = 32,
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] END_WORD = END_WORD_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BYTE_W-1:0]  rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [B-1:0]       imem_wdata,
   output logic               pipe_hold,
   output logic               done,
   output logic               error,
   output logic               csum_err,
   output logic [ADDR_W:0]    word_count,
   output logic [STATE_W-1:0] o_dbg_state
);

   logic [STATE_W-1:0] r_state;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W:0]    r_count;
   logic               r_done;
   logic               r_error;
   logic               r_pipe_hold;
   logic               w_accept;
   logic               w_restart;
   logic               w_word_valid;
   logic [B-1:0]       w_word;

   // Handshake: a byte transfers on any rising edge where rx_valid and
   // rx_ready are both high; rx_ready is a pure decode of the registered state.
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] r_csum;
   logic              r_csum_err;
   assign rx_ready = (r_state == S_COLLECT) || (r_state == S_CSUM);
   assign csum_err = r_csum_err;
`else
   assign rx_ready = (r_state == S_COLLECT);
   assign csum_err = 1'b0;
`endif

   assign w_accept  = rx_valid && rx_ready;
   assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_ERROR));

   imem_loader_assembler #(.B(B)) u_asm (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (w_restart),
      .i_accept     (w_accept && (r_state == S_COLLECT)),
      .i_byte       (rx_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_pipe_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum      <= '0;
         r_csum_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  r_addr      <= '0;
                  r_count     <= '0;
                  r_done      <= 1'b0;
                  r_error     <= 1'b0;
                  r_pipe_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum      <= '0;
                  r_csum_err  <= 1'b0;
`endif
                  r_state     <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ rx_data;
`endif
                  if (w_word_valid) r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_count <= r_count + 1'b1;
               if (w_word == END_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state     <= S_CSUM;
`else
                  r_done      <= 1'b1;
                  r_pipe_hold <= 1'b0;
                  r_state     <= S_DONE;
`endif
               end else if (r_addr == '1) begin
                  // Memory full without seeing the marker.
                  r_error <= 1'b1;
                  r_state <= S_ERROR;
               end else begin
                  r_addr  <= r_addr + 1'b1;
                  r_state <= S_COLLECT;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_accept) begin
                  if (rx_data == r_csum) begin
                     r_done      <= 1'b1;
                     r_pipe_hold <= 1'b0;
                     r_state     <= S_DONE;
                  end else begin
                     r_error    <= 1'b1;
                     r_csum_err <= 1'b1;
                     r_state    <= S_ERROR;
                  end
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_we     = (r_state == S_WRITE);
   assign imem_addr   = r_addr;
   assign imem_wdata  = w_word;
   assign pipe_hold   = r_pipe_hold;
   assign done        = r_done;
   assign error       = r_error;
   assign word_count  = r_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance (ADDR_W=10) and a small
// instance (ADDR_W=2) share the byte bus; writes are logged and scored.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic        start_b, rx_ready_b, imem_we_b, pipe_hold_b, done_b, error_b, csum_err_b;
   logic [9:0]  imem_addr_b;
   logic [31:0] imem_wdata_b;
   logic [10:0] word_count_b;
   logic [2:0]  dbg_b;

   logic        start_s, rx_ready_s, imem_we_s, pipe_hold_s, done_s, error_s, csum_err_s;
   logic [1:0]  imem_addr_s;
   logic [31:0] imem_wdata_s;
   logic [2:0]  word_count_s;
   logic [2:0]  dbg_s;

   logic [63:0] exp_q[$];
   logic [63:0] obs_b[$];
   logic [63:0] obs_s[$];
   int          n_vec = 0;
   int          n_err = 0;

   imem_loader u_big (
      .clk(clk), .reset(reset), .start(start_b), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready_b), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
      .imem_wdata(imem_wdata_b), .pipe_hold(pipe_hold_b), .done(done_b), .error(error_b),
      .csum_err(csum_err_b), .word_count(word_count_b), .o_dbg_state(dbg_b)
   );

   imem_loader #(.ADDR_W(2)) u_small (
      .clk(clk), .reset(reset), .start(start_s), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready_s), .imem_we(imem_we_s), .imem_addr(imem_addr_s),
      .imem_wdata(imem_wdata_s), .pipe_hold(pipe_hold_s), .done(done_s), .error(error_s),
      .csum_err(csum_err_s), .word_count(word_count_s), .o_dbg_state(dbg_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we_b === 1'b1) obs_b.push_back({22'b0, imem_addr_b, imem_wdata_b});
      if (imem_we_s === 1'b1) obs_s.push_back({30'b0, imem_addr_s, imem_wdata_s});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap, input bit sel);
      bit ok;
      ok = 1'b0;
      if (gap) begin
         rx_valid = 1'b0;
         @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if ((sel ? rx_ready_s : rx_ready_b) === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $error("FAIL accept_timeout: byte %h observed rx_ready=0 expected 1", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap, input bit sel);
      send_byte(w[31:24], gap, sel);
      send_byte(w[23:16], gap, sel);
      send_byte(w[15:8],  gap, sel);
      send_byte(w[7:0],   gap, sel);
   endtask

   task automatic pulse_start(input bit sel);
      rx_valid = 1'b0;
      if (sel) start_s = 1'b1; else start_b = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      start_b = 1'b0;
   endtask

   // Moves the big instance from the marker's write cycle to its final state.
   task automatic end_load(input logic [7:0] cs);
      @(posedge clk); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("csum_state", {29'b0, dbg_b}, {29'b0, S_CSUM});
      send_byte(cs, 1'b0, 1'b0);
`else
      rx_data = cs;
`endif
      rx_valid = 1'b0;
   endtask

   task automatic check_writes(input bit sel);
      logic [63:0] o;
      logic [63:0] e;
      check("write_count", sel ? obs_s.size() : obs_b.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = '1;
         if (sel && obs_s.size() > 0) o = obs_s.pop_front();
         else if (!sel && obs_b.size() > 0) o = obs_b.pop_front();
         check("write_addr", o[63:32], e[63:32]);
         check("write_data", o[31:0], e[31:0]);
      end
      obs_b.delete();
      obs_s.delete();
   endtask

   task automatic expect_program();
      exp_q.push_back({32'd0, 32'h2000_0005});
      exp_q.push_back({32'd1, 32'hFFFF_FFFF});
   endtask

   initial begin
      reset    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      start_b  = 1'b0;
      start_s  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      check("rst_state",      {29'b0, dbg_b}, {29'b0, S_IDLE});
      check("rst_pipe_hold",  {31'b0, pipe_hold_b}, 32'd1);
      check("rst_rx_ready",   {31'b0, rx_ready_b}, 32'd0);
      check("rst_imem_we",    {31'b0, imem_we_b}, 32'd0);
      check("rst_done",       {31'b0, done_b}, 32'd0);
      check("rst_error",      {31'b0, error_b}, 32'd0);
      check("rst_csum_err",   {31'b0, csum_err_b}, 32'd0);
      check("rst_imem_addr",  {22'b0, imem_addr_b}, 32'd0);
      check("rst_imem_wdata", imem_wdata_b, 32'd0);
      check("rst_word_count", {21'b0, word_count_b}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Async reset in the middle of a word.
      pulse_start(1'b0);
      send_byte(8'h20, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      rx_valid = 1'b0;
      check("mid_collect_ready", {31'b0, rx_ready_b}, 32'd1);
      #3 reset = 1'b0;
      #1;
      check("arst_state",      {29'b0, dbg_b}, {29'b0, S_IDLE});
      check("arst_pipe_hold",  {31'b0, pipe_hold_b}, 32'd1);
      check("arst_imem_we",    {31'b0, imem_we_b}, 32'd0);
      check("arst_word_count", {21'b0, word_count_b}, 32'd0);
      check("arst_rx_ready",   {31'b0, rx_ready_b}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_writes(1'b0);

      // Back-to-back stream with rx_valid held high.
      pulse_start(1'b0);
      send_byte(8'h20, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h05, 1'b0, 1'b0);
      check("lat_we",    {31'b0, imem_we_b}, 32'd1);
      check("lat_addr",  {22'b0, imem_addr_b}, 32'd0);
      check("lat_wdata", imem_wdata_b, 32'h2000_0005);
      send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
      check("mark_addr",  {22'b0, imem_addr_b}, 32'd1);
      check("mark_wdata", imem_wdata_b, 32'hFFFF_FFFF);
      check("mark_done_pre", {31'b0, done_b}, 32'd0);
      end_load(8'h25);
      check("a_done",       {31'b0, done_b}, 32'd1);
      check("a_pipe_hold",  {31'b0, pipe_hold_b}, 32'd0);
      check("a_word_count", {21'b0, word_count_b}, 32'd2);
      check("a_error",      {31'b0, error_b}, 32'd0);
      check("a_csum_err",   {31'b0, csum_err_b}, 32'd0);
      check("a_addr",       {22'b0, imem_addr_b}, 32'd1);
      check("a_rx_ready",   {31'b0, rx_ready_b}, 32'd0);
      expect_program();
      check_writes(1'b0);

      // Bytes offered in DONE are refused.
      rx_valid = 1'b1;
      rx_data  = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      rx_valid = 1'b0;
      check("done_hold_state", {29'b0, dbg_b}, {29'b0, S_DONE});
      check_writes(1'b0);

      // Restart from DONE, toggled rx_valid, stray start mid-word.
      pulse_start(1'b0);
      check("re_done",       {31'b0, done_b}, 32'd0);
      check("re_pipe_hold",  {31'b0, pipe_hold_b}, 32'd1);
      check("re_word_count", {21'b0, word_count_b}, 32'd0);
      check("re_addr",       {22'b0, imem_addr_b}, 32'd0);
      check("re_rx_ready",   {31'b0, rx_ready_b}, 32'd1);
      send_byte(8'h20, 1'b1, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      pulse_start(1'b0);
      check("ign_state", {29'b0, dbg_b}, {29'b0, S_COLLECT});
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'h05, 1'b1, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
      end_load(8'h25);
      check("b_done",       {31'b0, done_b}, 32'd1);
      check("b_pipe_hold",  {31'b0, pipe_hold_b}, 32'd0);
      check("b_word_count", {21'b0, word_count_b}, 32'd2);
      expect_program();
      check_writes(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong check byte: 0x24 instead of 0x25.
      pulse_start(1'b0);
      send_word(32'h2000_0005, 1'b0, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
      end_load(8'h24);
      check("c_error",     {31'b0, error_b}, 32'd1);
      check("c_csum_err",  {31'b0, csum_err_b}, 32'd1);
      check("c_done",      {31'b0, done_b}, 32'd0);
      check("c_pipe_hold", {31'b0, pipe_hold_b}, 32'd1);
      expect_program();
      check_writes(1'b0);
`endif

      // Small memory fills without a marker.
      pulse_start(1'b1);
      send_word(32'h0000_0001, 1'b0, 1'b1);
      send_word(32'h0000_0002, 1'b0, 1'b1);
      send_word(32'h0000_0003, 1'b0, 1'b1);
      send_word(32'h0000_0004, 1'b0, 1'b1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      check("s_error",      {31'b0, error_s}, 32'd1);
      check("s_pipe_hold",  {31'b0, pipe_hold_s}, 32'd1);
      check("s_word_count", {29'b0, word_count_s}, 32'd4);
      check("s_done",       {31'b0, done_s}, 32'd0);
      check("s_addr",       {30'b0, imem_addr_s}, 32'd3);
      check("s_csum_err",   {31'b0, csum_err_s}, 32'd0);
      for (int k = 0; k < 4; k++) exp_q.push_back({k[31:0], k[31:0] + 32'd1});
      check_writes(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
